// File: rtl/holy_axi_pkg.sv
// Shared AXI4 definitions for the holy core memory-side slaves.
// Response/burst codes, FSM state encodings and bus widths.
package holy_axi_pkg;

   localparam int AXI_ID_W   = 4;
   localparam int AXI_DATA_W = 32;
   localparam int AXI_ADDR_W = 32;
   localparam int AXI_STRB_W = AXI_DATA_W / 8;

   localparam logic [2:0] AXI_SIZE_WORD = 3'b010;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } axi_resp_e;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } axi_burst_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wr_state_e;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_e;

   // Only full-word FIXED/INCR transfers are served; WRAP and the reserved code share burst[1].
   function automatic logic cfg_bad(input logic [1:0] burst, input logic [2:0] size);
      return burst[1] || (size != AXI_SIZE_WORD);
   endfunction

endpackage

// File: rtl/holy_axi_ram_slave_mem.sv
// Byte-writable word memory with one write port and one registered read port.
// A read and a write to the same word in one cycle return the old contents.
module holy_axi_ram_slave_mem
   import holy_axi_pkg::*;
#(
   parameter int MEM_WORDS = 4096,
   parameter int IDX_W     = $clog2(MEM_WORDS)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [IDX_W-1:0]      widx,
   input  logic [AXI_STRB_W-1:0] wbe,
   input  logic [AXI_DATA_W-1:0] wdata,
   input  logic                  re,
   input  logic [IDX_W-1:0]      ridx,
   output logic [AXI_DATA_W-1:0] rdata
);

   logic [AXI_DATA_W-1:0] mem [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < AXI_STRB_W; b++) begin
            if (wbe[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (re) rdata <= mem[ridx];
   end

endmodule

// File: rtl/holy_axi_ram_slave.sv
// AXI4 slave backed by on-chip RAM; independent read and write engines,
// one outstanding transaction per direction, all handshake outputs registered.
module holy_axi_ram_slave
   import holy_axi_pkg::*;
#(
   parameter int          MEM_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [AXI_ID_W-1:0]   s_axi_awid,
   input  logic [AXI_ADDR_W-1:0] s_axi_awaddr,
   input  logic [7:0]            s_axi_awlen,
   input  logic [2:0]            s_axi_awsize,
   input  logic [1:0]            s_axi_awburst,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [AXI_DATA_W-1:0] s_axi_wdata,
   input  logic [AXI_STRB_W-1:0] s_axi_wstrb,
   input  logic                  s_axi_wlast,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [AXI_ID_W-1:0]   s_axi_bid,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [AXI_ID_W-1:0]   s_axi_arid,
   input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
   input  logic [7:0]            s_axi_arlen,
   input  logic [2:0]            s_axi_arsize,
   input  logic [1:0]            s_axi_arburst,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [AXI_ID_W-1:0]   s_axi_rid,
   output logic [AXI_DATA_W-1:0] s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rlast,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready
);

   localparam int          IDX_W     = $clog2(MEM_WORDS);
   localparam logic [32:0] MEM_BYTES = 33'(longint'(MEM_WORDS) * 4);

   // Addresses carry a 33rd bit so an INCR burst running off the 4 GiB top stays out of range.
   function automatic logic in_range(input logic [32:0] a);
      return (a - {1'b0, BASE_ADDR}) < MEM_BYTES;
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [32:0] a);
      return IDX_W'((a - {1'b0, BASE_ADDR}) >> 2);
   endfunction

   function automatic logic [32:0] next_addr(input logic [32:0] a, input logic [1:0] burst);
      return (burst == BURST_INCR) ? a + 33'd4 : a;
   endfunction

   wr_state_e w_state;
   logic [32:0] w_addr;
   logic [7:0]  w_len;
   logic [7:0]  w_cnt;
   logic [1:0]  w_burst;
   logic        w_cfg_err;
   logic        w_err;
   logic        aw_hs, w_hs, b_hs;
   logic        w_last_beat, w_beat_err, mem_we;

   assign aw_hs       = s_axi_awvalid && s_axi_awready;
   assign w_hs        = s_axi_wvalid && s_axi_wready;
   assign b_hs        = s_axi_bvalid && s_axi_bready;
   assign w_last_beat = (w_cnt == w_len);
   assign w_beat_err  = w_cfg_err || !in_range(w_addr) || (s_axi_wlast != w_last_beat);
   assign mem_we      = w_hs && !w_beat_err;

   always_ff @(posedge clk) begin
      if (aw_hs) begin
         w_addr    <= {1'b0, s_axi_awaddr};
         w_len     <= s_axi_awlen;
         w_burst   <= s_axi_awburst;
         w_cfg_err <= cfg_bad(s_axi_awburst, s_axi_awsize);
         w_cnt     <= 8'd0;
      end else if (w_hs) begin
         w_addr <= next_addr(w_addr, w_burst);
         w_cnt  <= w_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state       <= W_IDLE;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bid     <= '0;
         s_axi_bresp   <= RESP_OKAY;
         w_err         <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               s_axi_awready <= 1'b1;
               if (aw_hs) begin
                  s_axi_awready <= 1'b0;
                  s_axi_wready  <= 1'b1;
                  s_axi_bid     <= s_axi_awid;
                  w_err         <= 1'b0;
                  w_state       <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_hs) begin
                  w_err <= w_err || w_beat_err;
                  if (w_last_beat) begin
                     s_axi_wready <= 1'b0;
                     s_axi_bvalid <= 1'b1;
                     s_axi_bresp  <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                     w_state      <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (b_hs) begin
                  s_axi_bvalid  <= 1'b0;
                  s_axi_awready <= 1'b1;
                  w_state       <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   rd_state_e r_state;
   logic [32:0] r_addr, r_addr_nxt, rd_load_addr;
   logic [7:0]  r_len;
   logic [7:0]  r_cnt;
   logic [1:0]  r_burst;
   logic        r_cfg_err;
   logic        r_err;
   logic        ar_hs, r_hs, rd_load;
   logic [AXI_DATA_W-1:0] mem_q;

   assign ar_hs        = s_axi_arvalid && s_axi_arready;
   assign r_hs         = s_axi_rvalid && s_axi_rready;
   assign r_addr_nxt   = next_addr(r_addr, r_burst);
   assign rd_load      = ar_hs || (r_hs && !s_axi_rlast);
   assign rd_load_addr = ar_hs ? {1'b0, s_axi_araddr} : r_addr_nxt;

   // Read data comes straight from the RAM output register, masked on error beats and outside a burst.
   assign s_axi_rdata = (s_axi_rvalid && !r_err) ? mem_q : '0;
   assign s_axi_rresp = (s_axi_rvalid && r_err) ? RESP_SLVERR : RESP_OKAY;

   always_ff @(posedge clk) begin
      if (ar_hs) begin
         r_addr    <= {1'b0, s_axi_araddr};
         r_len     <= s_axi_arlen;
         r_burst   <= s_axi_arburst;
         r_cfg_err <= cfg_bad(s_axi_arburst, s_axi_arsize);
         r_cnt     <= 8'd0;
      end else if (r_hs && !s_axi_rlast) begin
         r_addr <= r_addr_nxt;
         r_cnt  <= r_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= R_IDLE;
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rlast   <= 1'b0;
         s_axi_rid     <= '0;
         r_err         <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: begin
               s_axi_arready <= 1'b1;
               if (ar_hs) begin
                  s_axi_arready <= 1'b0;
                  s_axi_rvalid  <= 1'b1;
                  s_axi_rid     <= s_axi_arid;
                  s_axi_rlast   <= (s_axi_arlen == 8'd0);
                  r_err         <= cfg_bad(s_axi_arburst, s_axi_arsize) ||
                                   !in_range({1'b0, s_axi_araddr});
                  r_state       <= R_DATA;
               end
            end
            R_DATA: begin
               if (r_hs) begin
                  if (s_axi_rlast) begin
                     s_axi_rvalid  <= 1'b0;
                     s_axi_rlast   <= 1'b0;
                     s_axi_arready <= 1'b1;
                     r_state       <= R_IDLE;
                  end else begin
                     s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
                     r_err       <= r_cfg_err || !in_range(r_addr_nxt);
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   holy_axi_ram_slave_mem #(
      .MEM_WORDS (MEM_WORDS),
      .IDX_W     (IDX_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .widx  (word_idx(w_addr)),
      .wbe   (s_axi_wstrb),
      .wdata (s_axi_wdata),
      .re    (rd_load),
      .ridx  (word_idx(rd_load_addr)),
      .rdata (mem_q)
   );

endmodule
